// File: rtl/break_sequencer_pkg.sv
// Shared types and constants for the 7-cycle break sequencer (RESET/NMI/IRQ/BRK).
// The sequence-state encoding doubles as the externally visible cycle number.
package break_sequencer_pkg;

  typedef enum logic [1:0] {
    SRC_BRK = 2'd0,
    SRC_IRQ = 2'd1,
    SRC_NMI = 2'd2,
    SRC_RES = 2'd3
  } brk_src_e;

  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_PCH  = 2'd1,
    PUSH_PCL  = 2'd2,
    PUSH_P    = 2'd3
  } push_sel_e;

  // Encoded so that seq_cyc can be driven straight from the state register.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DUMMY    = 3'd1,
    ST_PUSH_PCH = 3'd2,
    ST_PUSH_PCL = 3'd3,
    ST_PUSH_P   = 3'd4,
    ST_VEC_LO   = 3'd5,
    ST_VEC_HI   = 3'd6
  } seq_state_e;

  localparam logic [2:0] VEC_NMI  = 3'b010;
  localparam logic [2:0] VEC_RES  = 3'b100;
  localparam logic [2:0] VEC_IRQ  = 3'b110;
  localparam logic [2:0] SEQ_LAST = 3'd6;

  function automatic logic [2:0] vec_base(input brk_src_e s);
    case (s)
      SRC_NMI: return VEC_NMI;
      SRC_RES: return VEC_RES;
      default: return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/break_sequencer_if.sv
// Pin-side requests and datapath/bus-control strobes of the break sequencer.
// master = the sequencer itself, slave = the surrounding core / testbench.
interface break_sequencer_if;

  logic                         NMI_N;
  logic                         IRQ_N;
  logic                         rdy;
  logic                         t0;
  logic                         brk_op;
  logic                         i_flag;

  logic                         busy;
  logic [2:0]                   seq_cyc;
  break_sequencer_pkg::brk_src_e  src;
  logic                         wr_en;
  break_sequencer_pkg::push_sel_e push_sel;
  logic                         b_flag;
  logic                         sp_dec;
  logic [2:0]                   vec_lo;
  logic                         vec_fetch;
  logic                         set_i;
  logic                         brk_done;

  modport master (
    input  NMI_N, IRQ_N, rdy, t0, brk_op, i_flag,
    output busy, seq_cyc, src, wr_en, push_sel, b_flag, sp_dec,
           vec_lo, vec_fetch, set_i, brk_done
  );

  modport slave (
    output NMI_N, IRQ_N, rdy, t0, brk_op, i_flag,
    input  busy, seq_cyc, src, wr_en, push_sel, b_flag, sp_dec,
           vec_lo, vec_fetch, set_i, brk_done
  );

endinterface

// File: rtl/break_sequencer_nmi_edge_latch.sv
// Falling-edge detector for the NMI pin with a sticky pending flag.
// A new edge in the same cycle as a clear wins, so no NMI is ever lost.
module nmi_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic clr,
  output logic nmi_pend
);

  logic nmi_prev;
  logic nmi_fall;

  assign nmi_fall = nmi_prev & ~nmi_n;

  // prev resets high so a pin already held low after reset counts as one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev <= 1'b1;
      nmi_pend <= 1'b0;
    end else begin
      nmi_prev <= nmi_n;
      if (nmi_fall) begin
        nmi_pend <= 1'b1;
      end else if (clr) begin
        nmi_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/break_sequencer.sv
// Break sequencer: arbitrates RESET/NMI/IRQ/BRK at instruction boundaries and
// walks the dummy-read, three pushes and two vector fetches, then sets I.
module break_sequencer
  import break_sequencer_pkg::*;
#(
  parameter bit SUPPRESS_RES_WR = 1'b1,
  parameter int NMI_HIJACK_LAST = 4
) (
  input  logic              clk_1,
  input  logic              res_p,
  break_sequencer_if.master bus
);

  localparam logic [2:0] HIJACK_CYC = 3'(NMI_HIJACK_LAST);

  seq_state_e state, state_next;
  brk_src_e   src_q, src_next;
  logic       res_pend;
  logic       res_start;
  logic       nmi_pend;
  logic       nmi_clr;
  logic       irq_req;
  logic       boundary;
  logic       hijack;

  assign irq_req  = ~bus.IRQ_N & ~bus.i_flag;
  assign boundary = bus.t0 & bus.rdy;
  assign nmi_clr  = (state == ST_VEC_LO) && (src_q == SRC_NMI) && bus.rdy;
  assign hijack   = (state != ST_IDLE) && (state <= HIJACK_CYC) && nmi_pend &&
                    ((src_q == SRC_IRQ) || (src_q == SRC_BRK));

  nmi_edge_latch u_nmi (
    .clk      (clk_1),
    .rst      (res_p),
    .nmi_n    (bus.NMI_N),
    .clr      (nmi_clr),
    .nmi_pend (nmi_pend)
  );

  always_ff @(posedge clk_1) begin
    if (res_p) begin
      state    <= ST_IDLE;
      src_q    <= SRC_BRK;
      res_pend <= 1'b1;
    end else begin
      state <= state_next;
      src_q <= src_next;
      if (res_start) begin
        res_pend <= 1'b0;
      end
    end
  end

  // RESET starts unconditionally; the rest wait for a ready boundary, except a
  // mid-fetch BRK which only needs rdy because the opcode is decoded before t0.
  always_comb begin
    state_next = state;
    src_next   = src_q;
    res_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (res_pend) begin
          state_next = ST_DUMMY;
          src_next   = SRC_RES;
          res_start  = 1'b1;
        end else if (boundary && nmi_pend) begin
          state_next = ST_DUMMY;
          src_next   = SRC_NMI;
        end else if (boundary && irq_req) begin
          state_next = ST_DUMMY;
          src_next   = SRC_IRQ;
        end else if (bus.brk_op && bus.rdy) begin
          state_next = ST_DUMMY;
          src_next   = SRC_BRK;
        end
      end
      ST_DUMMY:    if (bus.rdy) state_next = ST_PUSH_PCH;
      ST_PUSH_PCH: state_next = ST_PUSH_PCL;
      ST_PUSH_PCL: state_next = ST_PUSH_P;
      ST_PUSH_P:   state_next = ST_VEC_LO;
      ST_VEC_LO:   if (bus.rdy) state_next = ST_VEC_HI;
      ST_VEC_HI:   if (bus.rdy) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
    if (hijack) begin
      src_next = SRC_NMI;
    end
  end

  always_comb begin
    bus.busy      = 1'b0;
    bus.seq_cyc   = 3'd0;
    bus.src       = SRC_BRK;
    bus.wr_en     = 1'b0;
    bus.push_sel  = PUSH_NONE;
    bus.b_flag    = 1'b0;
    bus.sp_dec    = 1'b0;
    bus.vec_lo    = 3'd0;
    bus.vec_fetch = 1'b0;
    bus.set_i     = 1'b0;
    bus.brk_done  = 1'b0;
    if (!res_p && (state != ST_IDLE)) begin
      bus.busy    = 1'b1;
      bus.seq_cyc = state;
      bus.src     = src_q;
      case (state)
        ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_P: begin
          bus.sp_dec = 1'b1;
          bus.wr_en  = !((src_q == SRC_RES) && SUPPRESS_RES_WR);
        end
        ST_VEC_LO: begin
          bus.vec_lo    = vec_base(src_q);
          bus.vec_fetch = 1'b1;
        end
        ST_VEC_HI: begin
          bus.vec_lo    = vec_base(src_q) | 3'b001;
          bus.vec_fetch = 1'b1;
          bus.set_i     = bus.rdy && (state == seq_state_e'(SEQ_LAST));
          bus.brk_done  = bus.rdy;
        end
        default: ;
      endcase
      case (state)
        ST_PUSH_PCH: bus.push_sel = PUSH_PCH;
        ST_PUSH_PCL: bus.push_sel = PUSH_PCL;
        ST_PUSH_P:   bus.push_sel = PUSH_P;
        default:     bus.push_sel = PUSH_NONE;
      endcase
      bus.b_flag = (state == ST_PUSH_P) && (src_q == SRC_BRK);
    end
  end

endmodule

// File: tb/tb_break_sequencer.sv
// Directed bench for break_sequencer: reset, IRQ, BRK, NMI hijack/late NMI,
// rdy stalls and a mid-sequence reset, checked cycle by cycle.
module tb_break_sequencer;

  logic clk_1;
  logic res_p;
  int   compared;
  int   mismatched;
  int   edge_cnt;
  int   start_cnt;

  break_sequencer_if sif ();

  break_sequencer #(
    .SUPPRESS_RES_WR (1'b1),
    .NMI_HIJACK_LAST (4)
  ) dut (
    .clk_1 (clk_1),
    .res_p (res_p),
    .bus   (sif)
  );

  initial clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  // Expected output vector {busy,seq_cyc,src,wr_en,push_sel,b_flag,sp_dec,vec_lo,vec_fetch,set_i,brk_done}.
  function automatic logic [16:0] exp_vec(input int cyc, input int s, input logic r);
    logic       busy_e, wr_e, b_e, sp_e, vf_e, si_e, dn_e;
    logic [2:0] seq_e, v_e, base;
    logic [1:0] src_e, ps_e;
    busy_e = 0; wr_e = 0; b_e = 0; sp_e = 0; vf_e = 0; si_e = 0; dn_e = 0;
    seq_e = 0; v_e = 0; src_e = 0; ps_e = 0;
    base = (s == 2) ? 3'b010 : (s == 3) ? 3'b100 : 3'b110;
    if (cyc != 0) begin
      busy_e = 1; seq_e = 3'(cyc); src_e = 2'(s);
    end
    if (cyc >= 2 && cyc <= 4) begin
      wr_e = (s != 3); ps_e = 2'(cyc - 1); sp_e = 1; b_e = (cyc == 4) && (s == 0);
    end
    if (cyc == 5) begin
      v_e = base; vf_e = 1;
    end
    if (cyc == 6) begin
      v_e = base | 3'b001; vf_e = 1; si_e = r; dn_e = r;
    end
    return {busy_e, seq_e, src_e, wr_e, ps_e, b_e, sp_e, v_e, vf_e, si_e, dn_e};
  endfunction

  task automatic tick();
    @(posedge clk_1);
    #1;
    edge_cnt++;
  endtask

  task automatic applyStimulus(input logic nmi_n, input logic irq_n, input logic r,
                               input logic t, input logic brk, input logic ifl);
    sif.NMI_N = nmi_n; sif.IRQ_N = irq_n; sif.rdy = r;
    sif.t0 = t; sif.brk_op = brk; sif.i_flag = ifl;
  endtask

  task automatic checkOutput(input string tag, input int cyc, input int s);
    logic [16:0] obs, exp;
    #1;
    obs = {sif.busy, sif.seq_cyc, sif.src, sif.wr_en, sif.push_sel, sif.b_flag,
           sif.sp_dec, sif.vec_lo, sif.vec_fetch, sif.set_i, sif.brk_done};
    exp = exp_vec(cyc, s, sif.rdy);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s c%0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic run_seq(input int s, input string tag);
    for (int c = 1; c <= 6; c++) begin
      tick();
      checkOutput(tag, c, s);
    end
  endtask

  task automatic finish_idle(input string tag);
    tick();
    sif.IRQ_N = 1'b1;
    sif.brk_op = 1'b0;
    checkOutput(tag, 0, 0);
  endtask

  initial begin
    compared = 0; mismatched = 0; edge_cnt = 0;
    res_p = 1'b1;
    applyStimulus(1, 1, 1, 0, 0, 0);

    // Reset held for 3 clocks, then RESET sequence without t0; pushes are reads.
    repeat (3) tick();
    checkOutput("reset", 0, 0);
    res_p = 1'b0;
    checkOutput("reset_rel", 0, 0);
    run_seq(3, "res_seq");
    finish_idle("res_end");

    // Unmasked IRQ at a boundary.
    applyStimulus(1, 0, 1, 1, 0, 0);
    run_seq(1, "irq");
    finish_idle("irq_end");

    // Masked IRQ is ignored; BRK wins and pushes B=1.
    applyStimulus(1, 0, 1, 1, 0, 1);
    repeat (3) begin
      tick();
      checkOutput("masked", 0, 0);
    end
    sif.brk_op = 1'b1;
    run_seq(0, "brk");
    finish_idle("brk_end");

    // BRK accepted without t0.
    applyStimulus(1, 1, 1, 0, 1, 0);
    run_seq(0, "brk_t0lo");
    finish_idle("brk_t0lo_end");

    // NMI edge during IRQ cycle 3 retargets the vector.
    applyStimulus(1, 0, 1, 1, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checkOutput("hijack", c, 1);
    end
    sif.NMI_N = 1'b0;
    tick(); checkOutput("hijack", 4, 1);
    tick(); checkOutput("hijack", 5, 2);
    tick(); checkOutput("hijack", 6, 2);
    finish_idle("hijack_end");
    repeat (2) begin
      tick();
      checkOutput("nmi_level", 0, 0);
    end
    sif.NMI_N = 1'b1;
    tick();
    checkOutput("nmi_high", 0, 0);

    // NMI edge during cycle 5 is too late; it runs at the next boundary.
    applyStimulus(1, 0, 1, 1, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      checkOutput("late", c, 1);
    end
    sif.NMI_N = 1'b0;
    tick();
    checkOutput("late", 6, 1);
    finish_idle("late_end");
    run_seq(2, "nmi_late");
    finish_idle("nmi_late_end");
    sif.NMI_N = 1'b1;
    tick();
    checkOutput("nmi_late_idle", 0, 0);

    // rdy low stalls read cycles 1 and 5 only: 11 clocks boundary-to-idle.
    applyStimulus(1, 0, 1, 1, 0, 0);
    start_cnt = edge_cnt;
    tick(); checkOutput("stall", 1, 1);
    sif.rdy = 1'b0; checkOutput("stall", 1, 1);
    tick(); checkOutput("stall", 1, 1);
    tick(); sif.rdy = 1'b1; checkOutput("stall", 1, 1);
    tick(); checkOutput("stall", 2, 1);
    sif.rdy = 1'b0; checkOutput("stall", 2, 1);
    tick(); sif.rdy = 1'b1; checkOutput("stall", 3, 1);
    tick(); checkOutput("stall", 4, 1);
    tick(); checkOutput("stall", 5, 1);
    sif.rdy = 1'b0; checkOutput("stall", 5, 1);
    tick(); checkOutput("stall", 5, 1);
    tick(); sif.rdy = 1'b1; checkOutput("stall", 5, 1);
    tick(); checkOutput("stall", 6, 1);
    sif.rdy = 1'b0; checkOutput("stall_nopulse", 6, 1);
    sif.rdy = 1'b1; checkOutput("stall_pulse", 6, 1);
    finish_idle("stall_end");
    compared++;
    assert ((edge_cnt - start_cnt) == 11) else begin
      mismatched++;
      $error("[TB] FAIL stall_len: observed %0d clocks expected 11", edge_cnt - start_cnt);
    end

    // Reset during IRQ cycle 4 with NMI held low: abort, RESET, then one NMI.
    applyStimulus(1, 0, 1, 1, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput("abort", c, 1);
    end
    res_p = 1'b1;
    sif.NMI_N = 1'b0;
    checkOutput("abort_now", 0, 0);
    tick();
    checkOutput("abort_edge", 0, 0);
    res_p = 1'b0;
    sif.IRQ_N = 1'b1;
    sif.t0 = 1'b0;
    checkOutput("abort_rel", 0, 0);
    run_seq(3, "res2");
    finish_idle("res2_end");
    sif.t0 = 1'b1;
    run_seq(2, "nmi_once");
    finish_idle("nmi_once_end");
    repeat (2) begin
      tick();
      checkOutput("nmi_once_idle", 0, 0);
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
